// File: rtl/vend_pkg.sv
// Shared types and constants for the vending credit controller: state encoding,
// status codes, coin values and the product price table.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT   = 2'd0,
    ST_DISPENSE  = 2'd1,
    ST_REJ_FUNDS = 2'd2,
    ST_REJ_INV   = 2'd3
  } state_t;

  localparam logic [1:0] STAT_COLLECT  = 2'd0;
  localparam logic [1:0] STAT_DISPENSE = 2'd1;
  localparam logic [1:0] STAT_NO_FUNDS = 2'd2;
  localparam logic [1:0] STAT_INVALID  = 2'd3;

  localparam logic [6:0] COIN_1     = 7'd1;
  localparam logic [6:0] COIN_2     = 7'd2;
  localparam logic [6:0] COIN_5     = 7'd5;
  localparam logic [6:0] MAX_CREDIT = 7'd99;

  // A price of zero marks an unassigned product code.
  function automatic logic [6:0] price_of(input logic [3:0] code);
    case (code)
      4'd0:    price_of = 7'd3;
      4'd1:    price_of = 7'd4;
      4'd2:    price_of = 7'd5;
      4'd3:    price_of = 7'd6;
      4'd4:    price_of = 7'd7;
      4'd5:    price_of = 7'd8;
      4'd6:    price_of = 7'd10;
      4'd7:    price_of = 7'd12;
      4'd8:    price_of = 7'd15;
      4'd9:    price_of = 7'd20;
      default: price_of = 7'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_btn_cond.sv
// Button conditioner: 2-flop synchronizer, optional debounce filter
// (VEND_DEBOUNCE_EN) and falling-edge detector producing a one-cycle press.
module vend_btn_cond #(
  parameter int DEB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

`ifdef VEND_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif

  logic sync_p0, sync_p1;
  logic level, level_prev;

  // Synchronizer stage; idle level of an active-low button is 1
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= btn_n;
      sync_p1 <= sync_p0;
    end
  end

  generate
    if (DEB_EN && (DEB_CYCLES > 0)) begin : g_deb
      localparam int CW = $clog2(DEB_CYCLES + 1);
      logic [CW-1:0] deb_cnt;
      logic          deb_level;

      // Filter stage: level follows only after DEB_CYCLES consecutive disagreements
      always_ff @(posedge clk) begin
        if (rst) begin
          deb_level <= 1'b1;
          deb_cnt   <= '0;
        end else if (sync_p1 == deb_level) begin
          deb_cnt <= '0;
        end else if (deb_cnt == CW'(DEB_CYCLES - 1)) begin
          deb_level <= sync_p1;
          deb_cnt   <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end
      assign level = deb_level;
    end else begin : g_nodeb
      assign level = sync_p1;
    end
  endgenerate

  // Edge stage: registered so the press reaches the controller one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      level_prev <= 1'b1;
      press      <= 1'b0;
    end else begin
      level_prev <= level;
      press      <= level_prev & ~level;
    end
  end

endmodule

// File: rtl/vend_credit_ctrl.sv
// Vending credit controller: accumulates coin credit, checks it against the
// price table and sequences dispense/reject. Optional debounce: VEND_DEBOUNCE_EN.
module vend_credit_ctrl
  import vend_pkg::*;
#(
  parameter int DEB_CYCLES  = 500_000,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic       CLOCK_50,
  input  logic       RST,
  input  logic       b1,
  input  logic       b2,
  input  logic       b5,
  input  logic       bOK,
  input  logic [3:0] chave,
  output logic [3:0] hex1,
  output logic [3:0] hex0,
  output logic [1:0] status,
  output logic       led
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  logic ev_b1, ev_b2, ev_b5, ev_ok;

  vend_btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_b1  (.clk(CLOCK_50), .rst(RST), .btn_n(b1),  .press(ev_b1));
  vend_btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_b2  (.clk(CLOCK_50), .rst(RST), .btn_n(b2),  .press(ev_b2));
  vend_btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_b5  (.clk(CLOCK_50), .rst(RST), .btn_n(b5),  .press(ev_b5));
  vend_btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_bok (.clk(CLOCK_50), .rst(RST), .btn_n(bOK), .press(ev_ok));

  function automatic logic [7:0] to_bcd(input logic [6:0] bin);
    logic [6:0] rem;
    logic [3:0] tens;
    rem  = bin;
    tens = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (rem >= 7'd10) begin
        rem  = rem - 7'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, rem[3:0]};
  endfunction

  state_t        state;
  logic [6:0]    credit;
  logic [HW-1:0] hold_cnt;
  logic [6:0]    coin;
  logic          coin_ev;
  logic [7:0]    coin_sum;
  logic [6:0]    price;
  logic          hold_done;

  // One coin per cycle, largest first
  always_comb begin
    coin    = '0;
    coin_ev = 1'b0;
    if (ev_b5) begin
      coin    = COIN_5;
      coin_ev = 1'b1;
    end else if (ev_b2) begin
      coin    = COIN_2;
      coin_ev = 1'b1;
    end else if (ev_b1) begin
      coin    = COIN_1;
      coin_ev = 1'b1;
    end
  end

  assign coin_sum  = {1'b0, credit} + {1'b0, coin};
  assign price     = price_of(chave);
  assign hold_done = (hold_cnt == HW'(HOLD_CYCLES - 1));

  // Control stage: credit and sequencing; presses outside COLLECT are discarded
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      state    <= ST_COLLECT;
      credit   <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        ST_COLLECT: begin
          hold_cnt <= '0;
          if (coin_ev) begin
            if (coin_sum <= {1'b0, MAX_CREDIT}) credit <= coin_sum[6:0];
          end else if (ev_ok) begin
            if (price == 7'd0) begin
              state <= ST_REJ_INV;
            end else if (credit < price) begin
              state <= ST_REJ_FUNDS;
            end else begin
              credit <= credit - price;
              state  <= ST_DISPENSE;
            end
          end
        end
        default: begin
          if (hold_done) begin
            hold_cnt <= '0;
            state    <= ST_COLLECT;
            if (state == ST_DISPENSE) credit <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Output stage: registered display, status and LED
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      hex1   <= 4'd0;
      hex0   <= 4'd0;
      status <= STAT_COLLECT;
      led    <= 1'b0;
    end else begin
      {hex1, hex0} <= to_bcd(credit);
      led          <= (state == ST_DISPENSE);
      case (state)
        ST_DISPENSE:  status <= STAT_DISPENSE;
        ST_REJ_FUNDS: status <= STAT_NO_FUNDS;
        ST_REJ_INV:   status <= STAT_INVALID;
        default:      status <= STAT_COLLECT;
      endcase
    end
  end

endmodule
